muldiv_sequencer: RTL and testbench

//  Execute-stage controller for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU in pipeline5.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_iter_dp.sv | 55 +++++
 rtl/muldiv_sequencer.sv | 148 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Also holds the operand-signedness helpers used when operands are launched.
package muldiv_pkg;

  localparam int MULDIV_XLEN  = 32;
  localparam int MULDIV_ITERS = MULDIV_XLEN;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // MULHSU treats rs2 as unsigned, so it is absent here.
  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// One-bit-per-cycle datapath: shift-add multiplier and restoring divider
// sharing a high/low register pair. Operands arrive as unsigned magnitudes.
module muldiv_iter_dp #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_nxt_o,
  output logic [XLEN-1:0] lo_nxt_o
);

  // hi: product upper half / partial remainder; lo: multiplier / dividend-then-quotient
  logic [XLEN-1:0] hi_q, lo_q, b_q;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_borrow;

  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift  = {hi_q, lo_q[XLEN-1]};
    div_borrow = (div_shift < {1'b0, b_q});
    // Only consumed when there is no borrow, where the difference fits XLEN bits.
    div_diff   = div_shift[XLEN-1:0] - b_q;
    if (is_div_i) begin
      hi_nxt_o = div_borrow ? div_shift[XLEN-1:0] : div_diff;
      lo_nxt_o = {lo_q[XLEN-2:0], ~div_borrow};
    end else begin
      hi_nxt_o = mul_sum[XLEN:1];
      lo_nxt_o = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else if (load_i) begin
      hi_q <= '0;
      lo_q <= a_i;
      b_q  <= b_i;
    end else if (step_i) begin
      hi_q <= hi_nxt_o;
      lo_q <= lo_nxt_o;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage RV32M sequencer: stalls F/D/E while the iterative datapath
// runs, then strobes the sign-corrected result for one cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output muldiv_state_e   state_o
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  // Handshake: start_i is a level held by the pipeline stall; a launch happens
  // on any edge where IDLE & start_i & ~flush_i. valid_o is a single-cycle
  // strobe with no back-pressure; result_o is meaningful only while valid_o.
  muldiv_state_e    state_q;
  muldiv_op_e       op_q;
  logic             neg_q;
  logic [CNT_W-1:0] count_q;
  logic [XLEN-1:0]  result_q;
  logic             valid_q;

  muldiv_op_e      op_in;
  logic            sa_in, sb_in, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            launch, step;

  logic [XLEN-1:0]   hi_nxt, lo_nxt;
  logic [2*XLEN-1:0] prod_full, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  always_comb begin
    op_in    = muldiv_op_e'(funct3_i);
    sa_in    = op_a_signed(op_in) & src_a_i[XLEN-1];
    sb_in    = op_b_signed(op_in) & src_b_i[XLEN-1];
    a_mag    = sa_in ? (~src_a_i + 1'b1) : src_a_i;
    b_mag    = sb_in ? (~src_b_i + 1'b1) : src_b_i;
    neg_in   = ((op_in == OP_REM) || (op_in == OP_REMU)) ? sa_in : (sa_in ^ sb_in);
    div_zero = op_is_div(op_in) && (src_b_i == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);
    special  = div_zero || div_ovf;
    // Division by zero wins over overflow (b cannot be both 0 and -1).
    if (div_zero)
      special_res = op_in[1] ? src_a_i : '1;
    else
      special_res = op_in[1] ? '0 : src_a_i;
    launch = (state_q == IDLE) && start_i && !flush_i;
    step   = (state_q == BUSY) && !flush_i;
  end

  muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (launch),
    .step_i   (step),
    .is_div_i (op_is_div(op_q)),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .hi_nxt_o (hi_nxt),
    .lo_nxt_o (lo_nxt)
  );

  // Sign fix uses the datapath's next values so the result registers on the
  // same edge that enters DONE.
  always_comb begin
    prod_full = {hi_nxt, lo_nxt};
    prod_fix  = neg_q ? (~prod_full + 1'b1) : prod_full;
    quot_fix  = neg_q ? (~lo_nxt + 1'b1) : lo_nxt;
    rem_fix   = neg_q ? (~hi_nxt + 1'b1) : hi_nxt;
    case (op_q)
      OP_MUL:                     final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            final_res = quot_fix;
      OP_REM, OP_REMU:            final_res = rem_fix;
      default:                    final_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (launch) begin
            op_q    <= op_in;
            neg_q   <= neg_in;
            count_q <= '0;
            if (special) begin
              state_q  <= DONE;
              result_q <= special_res;
              valid_q  <= 1'b1;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            count_q <= count_q + 1'b1;
            if (count_q == LAST_CNT) begin
              state_q  <= DONE;
              result_q <= final_res;
              valid_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // A flush landing in DONE kills the instruction in E, so the strobe is masked.
  assign valid_o  = valid_q && !flush_i;
  assign result_o = result_q;
  assign stall_o  = launch || (state_q == BUSY);
  assign state_o  = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases, flush,
// mid-operation reset and randomized operations against a reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] result_o;
  logic        valid_o;
  muldiv_state_e state_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .src_a_i  (src_a_i),
    .src_b_i  (src_b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .result_o (result_o),
    .valid_o  (valid_o),
    .state_o  (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      as_l, bs_l, bu_l;
    logic [63:0] p;
    int          ia, ib;
    as_l = longint'($signed(a));
    bs_l = longint'($signed(b));
    bu_l = longint'({32'h0, b});
    ia   = a;
    ib   = b;
    case (op)
      3'b000: begin p = as_l * bs_l; return p[31:0]; end
      3'b001: begin p = as_l * bs_l; return p[63:32]; end
      3'b010: begin p = as_l * bu_l; return p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (!op[0]) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  // driver: launch one op, wait for its strobe, score it
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold);
    logic [31:0] exp;
    int          lat, stall_cnt;
    bit          got;
    exp = model_res(op, a, b);
    lat = is_special(op, a, b) ? 1 : 33;
    exp_q.push_back(exp);
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = op;
    src_a_i  = a;
    src_b_i  = b;
    flush_i  = 1'b0;
    #1 check("stall_launch", 32'(stall_o), 32'd1);
    stall_cnt = 1;
    got = 1'b0;
    @(posedge clk);
    #1 if (!hold) start_i = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      if (stall_o) stall_cnt++;
      if (valid_o) begin
        got = 1'b1;
        check("latency", 32'(cyc), 32'(lat));
        if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else check("result", result_o, exp_q.pop_front());
      end
    end
    start_i = 1'b0;
    if (!got) begin
      check("valid_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    check("stall_cycles", 32'(stall_cnt), 32'(lat));
    @(negedge clk);
    check("valid_drop", 32'(valid_o), 32'd0);
    check("result_hold", result_o, exp);
    check("state_idle", 32'(state_o), 32'(IDLE));
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int vcnt;
    vcnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid_o) vcnt++;
    end
    check(tag, 32'(vcnt), 32'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset_n  = 1'b0;
    start_i  = 1'b0;
    funct3_i = 3'b000;
    src_a_i  = '0;
    src_b_i  = '0;
    flush_i  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    reset_n = 1'b1;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 1'b0);
    run_op(3'b111, 32'd100, 32'd7, 1'b0);
    run_op(3'b101, 32'd5, 32'd0, 1'b0);
    run_op(3'b110, 32'd5, 32'd0, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'd3, 1'b1);

    // flush in BUSY cycle 10
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b000; src_a_i = 32'd123; src_b_i = 32'd456;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_pre_state", 32'(state_o), 32'(BUSY));
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush_state", 32'(state_o), 32'(IDLE));
    check("flush_stall", 32'(stall_o), 32'd0);
    check("flush_valid", 32'(valid_o), 32'd0);
    watch_no_valid("flush_no_valid", 40);
    run_op(3'b000, 32'd123, 32'd456, 1'b0);

    // reset in BUSY cycle 5
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b101; src_a_i = 32'd1000; src_b_i = 32'd9;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_result", result_o, 32'd0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_stall", 32'(stall_o), 32'd0);
    check("mid_rst_state", 32'(state_o), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    watch_no_valid("rst_no_valid", 40);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 1'($urandom_range(0, 1)));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
